byte_mux_rr: RTL
================

// Module: byte_mux_rr
// PURPOSE
//  N-user byte-masked memory port multiplexer; successor of the fixed 4-user mux. Selectable arbitration,
//  grant locked across memory stalls, pipelined-read support (read data returns READ_LATENCY cycles after
//  accept, routed back to the issuing user). Sits between cores/DMA masters and one SRAM/bus port.
// PARAMETERS
//  USER          4      number of user ports, 2..16
//  DATA_BYTE     4      data width in bytes
//  ADDR_SIZE     32     address width
//  ARBITRATION   "RR"   "RR" round-robin | "PRIO" fixed priority, index 0 highest
//  READ_LATENCY  1      cycles from read accept to memReadData_i valid, 0..4
//  HOLDENABLE    1      1: useHold_o only when user enabled and not accepted; 0: also when another user is granted
// PORTS
//  clk_i              in   1                clock
//  rst_ni             in   1                reset, asynchronous, active-low
//  useEnable_i[USER]   in   1               request valid
//  useIsWrite_i[USER]  in   1               1 write, 0 read
//  useWriteMask_i[USER] in  DATA_BYTE       byte enables
//  useAddr_i[USER]     in   ADDR_SIZE       address
//  useWriteData_i[USER] in  DATA_BYTE*8     write data
//  useReadData_o[USER] out  DATA_BYTE*8     read data, valid with useReadValid_o, else 0
//  useReadValid_o[USER] out 1               read data strobe, one cycle per accepted read
//  useHold_o[USER]     out  1               request not accepted this cycle; user keeps request stable
//  memEnable_o/IsWrite_o/WriteMask_o/Addr_o/WriteData_o  out  as user  forwarded granted request
//  memReadData_i       in   DATA_BYTE*8     memory read data
//  memHold_i           in   1               memory stall; request not accepted, read pipeline frozen
// BEHAVIOUR
//  - Accept: user g granted, useEnable_i[g]=1, memHold_i=0. Grant and mem* outputs combinational.
//  - memEnable_o=0 and other mem* outputs =0 when no user granted.
//  - Lock: if granted request stalled by memHold_i, lock_q<=1, lockIdx_q<=g; while locked grant=lockIdx_q
//    regardless of other requests; lock clears on accept. Dropping enable while locked is illegal (assert).
//  - RR: grant = first enabled index scanning from ptr_q+1 wrapping modulo USER; ptr_q<=g on accept only.
//    PRIO: lowest enabled index; ptr_q unused.
//  - All USER enabled, RR, no stalls: grants cycle 0,1,..,USER-1,0.. one per cycle; no user waits >USER-1 accepts.
//  - Read pipe (READ_LATENCY>0): shift reg of {valid,idx}, depth READ_LATENCY; stage0 loaded with
//    {accept&!IsWrite, g}; shifts only when memHold_i=0; output stage valid -> useReadValid_o[idx]=1,
//    useReadData_o[idx]=memReadData_i. Writes enter as bubbles.
//  - READ_LATENCY=0: useReadValid_o[g]/useReadData_o[g] same cycle as read accept.
//  - Reset (async assert, sync release): ptr_q=USER-1 (user 0 first), lock_q=0, all pipe valid=0;
//    useReadValid_o=0, useReadData_o=0, memEnable_o=0 while rst_ni=0. In-flight reads dropped, never strobed.
//  - Simultaneous accept and read return to same user: both legal, independent.
//  - Widths: user index USER_W=$clog2(USER) (min 1); ptr wrap by explicit compare, not overflow.
// STRUCTURE
//  - Package byte_mux_pkg: arbitration mode enum (ARB_RR, ARB_PRIO), USER_W helper function,
//    read-pipe entry struct {valid, idx}.
//  - Sub-module byte_mux_arbiter: request vector + lock + ptr in, one-hot/index grant out (RR and PRIO).
//  - Top: arbiter instance, lock/ptr registers, read pipe, output muxing.
// TESTING
//  - Reset: rst_ni=0 mid-read with READ_LATENCY=2 -> no useReadValid_o after release; first grant = user 0.
//  - RR fairness: USER=4, all enabled reads, no stall -> accept order 0,1,2,3,0; useHold_o high for others.
//  - Lock: user 1 granted, memHold_i=1 for 3 cycles, user 0 enables -> grant stays 1, mem* stable, user 0 waits.
//  - Read routing: READ_LATENCY=2, reads by 2 then 0 back-to-back -> readValid[2] at t+2, readValid[0] at t+3,
//    data 0xA5A5_0002 / 0xA5A5_0000 as driven.
//  - Stall freeze: read accepted then memHold_i=1 for 2 cycles -> return delayed by exactly 2 cycles.
//  - PRIO + writes: users 0,3 write mask 4'b0101 -> user 0 first, mem mask 4'b0101, no readValid.

Source files
------------

// File: rtl/byte_mux_pkg.sv
// rtl/byte_mux_pkg.sv - shared types and helpers for the byte-masked memory port multiplexer
//
// Contents:
//   arb_mode_e  arbitration mode selector (round-robin or fixed priority)
//   user_w()    width of a user index, never less than one bit
//   RD_IDX_W    width of the index field kept in the read-return pipe (covers up to 16 users)
//   rd_entry_t  one read-return pipe stage: {valid, issuing user index}

package byte_mux_pkg;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_e;

    localparam int MAX_USER = 16;
    localparam int RD_IDX_W = 4;

    function automatic int user_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [RD_IDX_W-1:0] idx;
    } rd_entry_t;

endpackage

// File: rtl/byte_mux_arbiter.sv
// rtl/byte_mux_arbiter.sv - grant selection for the memory port multiplexer
//
// Ports:
//   req_i       per-user request vector
//   lock_i      a stalled grant is being held; forces grant to lock_idx_i
//   lock_idx_i  index of the held grant
//   ptr_i       last accepted user (round-robin start point, unused in priority mode)
//   gnt_oh_o    one-hot grant
//   gnt_idx_o   binary grant index
//   gnt_valid_o some user is granted

module byte_mux_arbiter
    import byte_mux_pkg::*;
#(
    parameter int        USER   = 4,
    parameter arb_mode_e MODE   = ARB_RR,
    parameter int        USER_W = user_w(USER)
) (
    input  logic [USER-1:0]   req_i,
    input  logic              lock_i,
    input  logic [USER_W-1:0] lock_idx_i,
    input  logic [USER_W-1:0] ptr_i,
    output logic [USER-1:0]   gnt_oh_o,
    output logic [USER_W-1:0] gnt_idx_o,
    output logic              gnt_valid_o
);

    int cand;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        gnt_oh_o    = '0;
        cand        = 0;
        if (lock_i) begin
            // A stalled request keeps the port until the memory takes it.
            gnt_valid_o = 1'b1;
            gnt_idx_o   = lock_idx_i;
        end else if (MODE == ARB_PRIO) begin
            // Scan downwards so the lowest enabled index is the last one written.
            for (int i = USER - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = USER_W'(i);
                end
            end
        end else begin
            // Offsets USER..1 from ptr; smallest offset is written last and wins.
            // Wrap by explicit compare so non-power-of-two USER works.
            for (int k = USER; k >= 1; k--) begin
                cand = int'(ptr_i) + k;
                if (cand >= USER) begin
                    cand = cand - USER;
                end
                if (req_i[cand[USER_W-1:0]]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = cand[USER_W-1:0];
                end
            end
        end
        if (gnt_valid_o) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/byte_mux_rr.sv
// rtl/byte_mux_rr.sv - N-user byte-masked memory port multiplexer with lock and pipelined read return
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   useEnable_i/IsWrite_i/WriteMask_i/Addr_i/WriteData_i   per-user request
//   useReadData_o, useReadValid_o per-user read return (data zero unless strobed)
//   useHold_o                     per-user "request not accepted this cycle"
//   memEnable_o/IsWrite_o/WriteMask_o/Addr_o/WriteData_o   granted request towards memory
//   memReadData_i                 memory read data
//   memHold_i                     memory stall

module byte_mux_rr
    import byte_mux_pkg::*;
#(
    parameter int    USER         = 4,
    parameter int    DATA_BYTE    = 4,
    parameter int    ADDR_SIZE    = 32,
    parameter string ARBITRATION  = "RR",
    parameter int    READ_LATENCY = 1,
    parameter int    HOLDENABLE   = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [USER-1:0]                      useEnable_i,
    input  logic [USER-1:0]                      useIsWrite_i,
    input  logic [USER-1:0][DATA_BYTE-1:0]       useWriteMask_i,
    input  logic [USER-1:0][ADDR_SIZE-1:0]       useAddr_i,
    input  logic [USER-1:0][DATA_BYTE*8-1:0]     useWriteData_i,
    output logic [USER-1:0][DATA_BYTE*8-1:0]     useReadData_o,
    output logic [USER-1:0]                      useReadValid_o,
    output logic [USER-1:0]                      useHold_o,
    output logic                                 memEnable_o,
    output logic                                 memIsWrite_o,
    output logic [DATA_BYTE-1:0]                 memWriteMask_o,
    output logic [ADDR_SIZE-1:0]                 memAddr_o,
    output logic [DATA_BYTE*8-1:0]               memWriteData_o,
    input  logic [DATA_BYTE*8-1:0]               memReadData_i,
    input  logic                                 memHold_i
);

    localparam int              USER_W   = user_w(USER);
    localparam arb_mode_e       ARB_MODE = (ARBITRATION == "PRIO") ? ARB_PRIO : ARB_RR;
    localparam logic [USER_W-1:0] PTR_RST = USER_W'(USER - 1);

    logic [USER-1:0]   gnt_oh;
    logic [USER_W-1:0] gnt_idx;
    logic              gnt_valid;

    logic              ptr_en_live;
    logic              accept;
    logic              stall;
    logic              rd_accept;
    logic [USER-1:0]   acc_vec;

    logic [USER_W-1:0] ptr_q, ptr_d;
    logic              lock_q, lock_d;
    logic [USER_W-1:0] lock_idx_q, lock_idx_d;

    logic                ret_valid;
    logic [RD_IDX_W-1:0] ret_idx;

    byte_mux_arbiter #(
        .USER   (USER),
        .MODE   (ARB_MODE),
        .USER_W (USER_W)
    ) u_arbiter (
        .req_i       (useEnable_i),
        .lock_i      (lock_q),
        .lock_idx_i  (lock_idx_q),
        .ptr_i       (ptr_q),
        .gnt_oh_o    (gnt_oh),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Granted user actually presenting a request; forced low in reset so
    // nothing reaches the memory while the block is held.
    assign ptr_en_live = rst_ni & gnt_valid & useEnable_i[gnt_idx];
    assign accept      = ptr_en_live & ~memHold_i;
    assign stall       = ptr_en_live & memHold_i;
    assign rd_accept   = accept & ~useIsWrite_i[gnt_idx];
    assign acc_vec     = accept ? gnt_oh : '0;

    // Forwarded request: all fields zero unless a user is granted.
    always_comb begin
        memEnable_o    = ptr_en_live;
        memIsWrite_o   = 1'b0;
        memWriteMask_o = '0;
        memAddr_o      = '0;
        memWriteData_o = '0;
        if (rst_ni && gnt_valid) begin
            memIsWrite_o   = useIsWrite_i[gnt_idx];
            memWriteMask_o = useWriteMask_i[gnt_idx];
            memAddr_o      = useAddr_i[gnt_idx];
            memWriteData_o = useWriteData_i[gnt_idx];
        end
    end

    always_comb begin
        useHold_o = '0;
        if (HOLDENABLE != 0) begin
            useHold_o = useEnable_i & ~acc_vec;
        end else begin
            // Users idle this cycle are also told to hold while someone else owns the port.
            useHold_o = (useEnable_i | ({USER{gnt_valid}} & ~gnt_oh)) & ~acc_vec;
        end
    end

    // Lock and round-robin pointer. The pointer only moves on a real accept,
    // so a stall never costs the stalled user its turn.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            lock_d = 1'b0;
            ptr_d  = gnt_idx;
        end else if (stall) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= PTR_RST;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    generate
        if (READ_LATENCY > 0) begin : g_pipe
            rd_entry_t pipe_q [READ_LATENCY];
            rd_entry_t head;

            // Writes and idle cycles enter as bubbles (valid=0).
            always_comb begin
                head.valid = rd_accept;
                head.idx   = RD_IDX_W'(gnt_idx);
            end

            // The pipe mirrors the memory's own pipeline, so it freezes with it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < READ_LATENCY; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (!memHold_i) begin
                    pipe_q[0] <= head;
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            // A frozen memory is not delivering data, so the strobe waits too;
            // this keeps it to exactly one cycle per read.
            assign ret_valid = pipe_q[READ_LATENCY-1].valid & ~memHold_i;
            assign ret_idx   = pipe_q[READ_LATENCY-1].idx;
        end else begin : g_nopipe
            assign ret_valid = rd_accept;
            assign ret_idx   = RD_IDX_W'(gnt_idx);
        end
    endgenerate

    always_comb begin
        useReadValid_o = '0;
        useReadData_o  = '0;
        for (int u = 0; u < USER; u++) begin
            if (ret_valid && (ret_idx == RD_IDX_W'(u))) begin
                useReadValid_o[u] = 1'b1;
                useReadData_o[u]  = memReadData_i;
            end
        end
    end

    lock_enable_held_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni) lock_q |-> useEnable_i[lock_idx_q]
    );

endmodule
